// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter turning per-requester set/clear/toggle commands into 1-cycle SR pulses on a shared flag bank.
// gnt/s/r/err register on the edge that samples req, q_vec one edge later; requesters hold req until granted.
module sr_flag_arbiter #(
   parameter int NREQ  = 4,
   parameter int FLAGS = 8,
   parameter int IW    = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [2*NREQ-1:0]    op,
   input  logic [IW*NREQ-1:0]   idx,
   output logic [NREQ-1:0]      gnt,
   output logic [FLAGS-1:0]     s_vec,
   output logic [FLAGS-1:0]     r_vec,
   output logic [FLAGS-1:0]     q_vec,
   output logic [FLAGS-1:0]     q_bar_vec,
   output logic                 err
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_CLR = 2'b01;
   localparam logic [1:0] OP_SET = 2'b10;
   localparam logic [1:0] OP_TOG = 2'b11;

   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     rr_nxt;
   logic [NREQ-1:0]   eligible;
   logic [2*NREQ-1:0] rot;
   logic              win_vld;
   logic [PW:0]       win_sum;
   logic [PW-1:0]     win;
   logic [NREQ-1:0]   gnt_nxt;
   logic [1:0]        win_op;
   logic [IW-1:0]     win_idx;
   logic [FLAGS-1:0]  q_eff;
   logic [FLAGS-1:0]  sel;
   logic [FLAGS-1:0]  s_nxt;
   logic [FLAGS-1:0]  r_nxt;
   logic              idx_bad;

   // A requester granted last cycle still holds req this cycle; masking it prevents a double grant.
   assign eligible = req & ~gnt;

   // Flag value once the pulses already on s_vec/r_vec land; toggles resolve against this.
   assign q_eff = (q_vec | s_vec) & ~r_vec;

   assign q_bar_vec = ~q_vec;

   always_comb begin
      rot     = {eligible, eligible} >> rr_ptr;
      win_vld = 1'b0;
      win_sum = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_vld && rot[k]) begin
            win_vld = 1'b1;
            win_sum = {1'b0, rr_ptr} + (PW+1)'(k);
         end
      end
      if (win_sum >= (PW+1)'(NREQ)) begin
         win_sum = win_sum - (PW+1)'(NREQ);
      end
      win = win_sum[PW-1:0];
      if (win == PW'(NREQ-1)) begin
         rr_nxt = '0;
      end else begin
         rr_nxt = win + PW'(1);
      end
   end

   always_comb begin
      gnt_nxt = '0;
      win_op  = OP_NOP;
      win_idx = '0;
      for (int n = 0; n < NREQ; n++) begin
         if (win_vld && (win == PW'(n))) begin
            gnt_nxt[n] = 1'b1;
            win_op     = op[2*n +: 2];
            win_idx    = idx[IW*n +: IW];
         end
      end
   end

   // An index with no matching flag leaves sel empty, so it can never pulse anything.
   always_comb begin
      sel     = '0;
      idx_bad = 1'b1;
      for (int f = 0; f < FLAGS; f++) begin
         if (win_idx == IW'(f)) begin
            sel[f]  = 1'b1;
            idx_bad = 1'b0;
         end
      end
      s_nxt = '0;
      r_nxt = '0;
      if (win_vld) begin
         case (win_op)
            OP_SET: s_nxt = sel;
            OP_CLR: r_nxt = sel;
            OP_TOG: begin
               s_nxt = sel & ~q_eff;
               r_nxt = sel & q_eff;
            end
            OP_NOP: ;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt    <= '0;
         s_vec  <= '0;
         r_vec  <= '0;
         err    <= 1'b0;
         q_vec  <= '0;
         rr_ptr <= '0;
      end else begin
         q_vec <= q_eff;
         s_vec <= s_nxt;
         r_vec <= r_nxt;
         err   <= win_vld & idx_bad;
         gnt   <= gnt_nxt;
         if (win_vld) begin
            rr_ptr <= rr_nxt;
         end
      end
   end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: directed requester commands, expected grant events scoreboarded and checked by a monitor.
module tb_sr_flag_arbiter;

   localparam logic [1:0] NOP = 2'b00;
   localparam logic [1:0] CLR = 2'b01;
   localparam logic [1:0] SET = 2'b10;
   localparam logic [1:0] TOG = 2'b11;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [7:0]  op;
   logic [11:0] idx;
   logic [3:0]  gnt;
   logic [7:0]  s_vec;
   logic [7:0]  r_vec;
   logic [7:0]  q_vec;
   logic [7:0]  q_bar_vec;
   logic        err;

   logic [3:0]  req6;
   logic [7:0]  op6;
   logic [11:0] idx6;
   logic [3:0]  gnt6;
   logic [5:0]  s6;
   logic [5:0]  r6;
   logic [5:0]  q6;
   logic [5:0]  qb6;
   logic        err6;

   sr_flag_arbiter #(.NREQ(4), .FLAGS(8), .IW(3)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
      .gnt(gnt), .s_vec(s_vec), .r_vec(r_vec), .q_vec(q_vec),
      .q_bar_vec(q_bar_vec), .err(err)
   );

   sr_flag_arbiter #(.NREQ(4), .FLAGS(6), .IW(3)) dut6 (
      .clk(clk), .rst_n(rst_n), .req(req6), .op(op6), .idx(idx6),
      .gnt(gnt6), .s_vec(s6), .r_vec(r6), .q_vec(q6),
      .q_bar_vec(qb6), .err(err6)
   );

   typedef struct packed {
      logic [1:0] op;
      logic [2:0] idx;
   } cmd_t;

   typedef struct packed {
      logic [3:0] g;
      logic [7:0] s;
      logic [7:0] r;
      logic       e;
      logic [7:0] qn;
   } exp_t;

   cmd_t cq0[$];
   cmd_t cq1[$];
   cmd_t cq2[$];
   cmd_t cq3[$];
   exp_t sb[$];

   int n_pass = 0;
   int n_total = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic expect_ev(input logic [3:0] g, input logic [7:0] s, input logic [7:0] r,
                            input logic e, input logic [7:0] qn);
      exp_t x;
      x.g = g; x.s = s; x.r = r; x.e = e; x.qn = qn;
      sb.push_back(x);
   endtask

   // Present the requester's next queued command, or drop its req when none is left.
   task automatic advance(input logic [1:0] who);
      cmd_t       c;
      logic       got;
      logic [3:0] sh2;
      logic [3:0] sh3;
      c   = '0;
      got = 1'b0;
      case (who)
         2'd0: if (cq0.size() != 0) begin c = cq0.pop_front(); got = 1'b1; end
         2'd1: if (cq1.size() != 0) begin c = cq1.pop_front(); got = 1'b1; end
         2'd2: if (cq2.size() != 0) begin c = cq2.pop_front(); got = 1'b1; end
         default: if (cq3.size() != 0) begin c = cq3.pop_front(); got = 1'b1; end
      endcase
      sh2 = {1'b0, who, 1'b0};
      sh3 = {2'b00, who} * 4'd3;
      req[who] = got;
      op  = (op  & ~(8'h3  << sh2)) | ((got ? 8'(c.op)   : 8'h0)  << sh2);
      idx = (idx & ~(12'h7 << sh3)) | ((got ? 12'(c.idx) : 12'h0) << sh3);
   endtask

   task automatic load(input logic [1:0] who, input logic [1:0] o, input logic [2:0] ix);
      cmd_t c;
      c.op  = o;
      c.idx = ix;
      case (who)
         2'd0: cq0.push_back(c);
         2'd1: cq1.push_back(c);
         2'd2: cq2.push_back(c);
         default: cq3.push_back(c);
      endcase
      if (!req[who]) advance(who);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (gnt[i]) advance(2'(i));
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL drain_timeout: %0d grant events still outstanding, expected 0", sb.size());
         sb.delete();
      end
      tick();
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0; op = '0; idx = '0;
      cq0.delete(); cq1.delete(); cq2.delete(); cq3.delete();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // One command on the 6-flag instance, checked directly at its grant and one cycle later.
   task automatic one6(input logic [1:0] who, input logic [1:0] o, input logic [2:0] ix,
                       input logic [5:0] es, input logic [5:0] er, input logic ee, input logic [5:0] eq);
      req6 = 4'b0001 << who;
      op6  = 8'(o) << {who, 1'b0};
      idx6 = 12'(ix) << ({2'b00, who} * 4'd3);
      @(posedge clk);
      #1 req6 = '0;
      @(negedge clk);
      chk("f6_gnt", 32'(gnt6), 32'(4'b0001 << who));
      chk("f6_s", 32'(s6), 32'(es));
      chk("f6_r", 32'(r6), 32'(er));
      chk("f6_err", 32'(err6), 32'(ee));
      @(negedge clk);
      chk("f6_err_pulse", 32'(err6), 32'h0);
      chk("f6_sr_pulse", 32'({s6, r6}), 32'h0);
      chk("f6_q", 32'(q6), 32'(eq));
   endtask

   // Monitor: pops one expected event per grant, checks q_vec on the following cycle, and invariants.
   initial begin
      exp_t       cur;
      logic       pend;
      logic [7:0] qexp;
      logic [3:0] pg;
      pend = 1'b0;
      qexp = '0;
      pg   = '0;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("q_after_grant", 32'(q_vec), 32'(qexp));
            pend = 1'b0;
         end
         if (rst_n === 1'b1) begin
            chk("s_and_r", 32'(s_vec & r_vec), 32'h0);
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'h1);
            chk("gnt_repeat", 32'(gnt & pg), 32'h0);
            chk("q_bar", 32'(q_bar_vec), 32'(8'(~q_vec)));
            chk("f6_s_and_r", 32'(s6 & r6), 32'h0);
         end
         if (gnt != 0 || s_vec != 0 || r_vec != 0 || err) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_event: gnt=%b s=%h r=%h err=%b, expected no event", gnt, s_vec, r_vec, err);
            end else begin
               cur = sb.pop_front();
               chk("gnt", 32'(gnt), 32'(cur.g));
               chk("s_vec", 32'(s_vec), 32'(cur.s));
               chk("r_vec", 32'(r_vec), 32'(cur.r));
               chk("err", 32'(err), 32'(cur.e));
               qexp = cur.qn;
               pend = 1'b1;
            end
         end
         pg = gnt;
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req = '0; op = '0; idx = '0;
      req6 = '0; op6 = '0; idx6 = '0;

      // Reset with all four requesters up, then each sets its own index in rotation.
      load(2'd0, SET, 3'd0);
      load(2'd1, SET, 3'd1);
      load(2'd2, SET, 3'd2);
      load(2'd3, SET, 3'd3);
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_s", 32'(s_vec), 32'h0);
      chk("rst_r", 32'(r_vec), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_q", 32'(q_vec), 32'h00);
      chk("rst_q_bar", 32'(q_bar_vec), 32'hFF);
      chk("rst_f6_q_bar", 32'(qb6), 32'h3F);
      expect_ev(4'b0001, 8'h01, 8'h00, 1'b0, 8'h01);
      expect_ev(4'b0010, 8'h02, 8'h00, 1'b0, 8'h03);
      expect_ev(4'b0100, 8'h04, 8'h00, 1'b0, 8'h07);
      expect_ev(4'b1000, 8'h08, 8'h00, 1'b0, 8'h0F);
      rst_n = 1'b1;
      wait_drain();

      // Req0 keeps req high across two commands; req1 must slot in between.
      do_reset();
      load(2'd0, SET, 3'd5);
      load(2'd0, SET, 3'd5);
      load(2'd1, SET, 3'd6);
      expect_ev(4'b0001, 8'h20, 8'h00, 1'b0, 8'h20);
      expect_ev(4'b0010, 8'h40, 8'h00, 1'b0, 8'h60);
      expect_ev(4'b0001, 8'h20, 8'h00, 1'b0, 8'h60);
      wait_drain();

      // Toggles resolving against pulses still in flight.
      do_reset();
      load(2'd1, SET, 3'd2);
      load(2'd2, TOG, 3'd2);
      load(2'd3, TOG, 3'd3);
      expect_ev(4'b0010, 8'h04, 8'h00, 1'b0, 8'h04);
      expect_ev(4'b0100, 8'h00, 8'h04, 1'b0, 8'h00);
      expect_ev(4'b1000, 8'h08, 8'h00, 1'b0, 8'h08);
      wait_drain();
      load(2'd0, NOP, 3'd0);
      expect_ev(4'b0001, 8'h00, 8'h00, 1'b0, 8'h08);
      wait_drain();
      load(2'd1, TOG, 3'd3);
      expect_ev(4'b0010, 8'h00, 8'h08, 1'b0, 8'h00);
      wait_drain();
      load(2'd2, SET, 3'd7);
      expect_ev(4'b0100, 8'h80, 8'h00, 1'b0, 8'h80);
      wait_drain();
      load(2'd3, CLR, 3'd7);
      load(2'd0, TOG, 3'd7);
      expect_ev(4'b1000, 8'h00, 8'h80, 1'b0, 8'h00);
      expect_ev(4'b0001, 8'h80, 8'h00, 1'b0, 8'h80);
      wait_drain();

      // Out-of-range indices on the 6-flag instance.
      one6(2'd2, SET, 3'd5, 6'h20, 6'h00, 1'b0, 6'h20);
      one6(2'd3, SET, 3'd7, 6'h00, 6'h00, 1'b1, 6'h20);
      one6(2'd0, CLR, 3'd6, 6'h00, 6'h00, 1'b1, 6'h20);
      one6(2'd1, TOG, 3'd5, 6'h00, 6'h20, 1'b0, 6'h00);

      // Reset lands between a set's grant and its flag update; survivors restart from slot 0.
      do_reset();
      load(2'd1, SET, 3'd1);
      load(2'd2, SET, 3'd2);
      load(2'd3, SET, 3'd3);
      expect_ev(4'b0010, 8'h02, 8'h00, 1'b0, 8'h00);
      tick();
      @(negedge clk);
      #1 rst_n = 1'b0;
      load(2'd0, SET, 3'd0);
      expect_ev(4'b0001, 8'h01, 8'h00, 1'b0, 8'h01);
      expect_ev(4'b0100, 8'h04, 8'h00, 1'b0, 8'h05);
      expect_ev(4'b1000, 8'h08, 8'h00, 1'b0, 8'h0D);
      tick();
      chk("mid_rst_q", 32'(q_vec), 32'h00);
      tick();
      rst_n = 1'b1;
      wait_drain();

      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
